scpad_tile_seq: RTL and testbench
=================================

SCPAD_TILE_SEQ -- requirements
Module: scpad_tile_seq

Interface
REQ-001 Parameters: NUM_SCPADS default 2, number of scratchpads; NUM_COLS default 32, banks per scratchpad (power of 2); NUM_ROWS default 2048, slots per bank (power of 2); MAX_TILE_SIZE default 32, maximum tile dimension (power of 2, no larger than NUM_COLS).
REQ-002 CLK  in  1  sole clock; RST  in  1  reset; one clock; reset is synchronous and active-high.
REQ-003 flush  in  1  synchronous abort of any tile in progress.
REQ-004 req_valid  in  1 / req_ready  out  1  tile-request handshake.
REQ-005 req_scpad_id  in  SCPAD_ID_WIDTH  target scratchpad.
REQ-006 req_base_row  in  ROW_IDX_WIDTH  first slot of the tile.
REQ-007 req_rows_m1, req_cols_m1  in  MAX_DIM_WIDTH each  tile rows-1 and cols-1.
REQ-008 req_transpose  in  1  0 = row-wise beats, 1 = column-wise beats.
REQ-009 beat_valid  out  1 / beat_ready  in  1  per-beat handshake.
REQ-010 beat_scpad_id  out  SCPAD_ID_WIDTH; beat_slot_mask  out  slot_mask_t; beat_shift_mask  out  shift_mask_t; beat_enable_mask  out  enable_mask_t.
REQ-011 beat_idx  out  MAX_DIM_WIDTH  current beat number; beat_last  out  1  final beat of tile; busy  out  1  tile in progress.

Function
REQ-012 The block SHALL use the skewed layout: tile element (r,c) resides in bank (c+r) mod NUM_COLS, slot (base+r) mod NUM_ROWS.
REQ-013 The FSM SHALL have two states: IDLE (req_ready=1, beat_valid=0) and RUN (req_ready=0, beat_valid=1, busy=1).
REQ-014 In IDLE, req_valid=1 SHALL latch all req_* fields, clear the beat counter, and enter RUN on the next edge; the first beat is valid exactly 1 cycle after acceptance.
REQ-015 Beat count SHALL be rows_m1+1 when transpose=0 and cols_m1+1 when transpose=1.
REQ-016 Row mode, beat i, lane k: slot = base+i, shift = (k+i) mod NUM_COLS, enable = (k <= cols_m1).
REQ-017 Transpose mode, beat j, lane k: slot = (base+k) mod NUM_ROWS, shift = (j+k) mod NUM_COLS, enable = (k <= rows_m1).
REQ-018 Lanes with enable=0 SHALL drive slot and shift to 0.
REQ-019 Slot arithmetic SHALL wrap modulo NUM_ROWS by truncation to ROW_IDX_WIDTH bits; shift arithmetic SHALL wrap by truncation to COL_IDX_WIDTH bits.
REQ-020 The beat counter SHALL advance only on beat_valid&&beat_ready; all beat_* outputs SHALL hold stable while beat_valid=1 and beat_ready=0.
REQ-021 beat_last SHALL be 1 when beat_idx equals the beat count minus 1; the handshake on the last beat SHALL return the FSM to IDLE, so req_ready=1 in the following cycle.
REQ-022 A one-beat tile (dimension_m1=0) SHALL issue a single beat with beat_last=1.
REQ-023 flush=1 SHALL force IDLE on the next edge from any state, dropping remaining beats; flush takes priority over both the request handshake and the beat handshake in the same cycle.
REQ-024 req_valid SHALL be ignored while in RUN; a request is never queued.

Reset
REQ-025 RST=1 SHALL, on the clock edge, force IDLE, with busy=0, beat_valid=0, req_ready=1, beat_idx=0, beat_last=0 and all masks 0; reset during RUN abandons the tile.
REQ-026 Reset SHALL take priority over flush and both handshakes.

Structure
REQ-027 spad_types_pkg SHALL hold NUM_SCPADS and the derived SCPAD_ID_WIDTH as parameters, plus MAX_DIM_WIDTH, ROW_IDX_WIDTH, COL_IDX_WIDTH, slot_mask_t, shift_mask_t, enable_mask_t and a tile_req_t struct.
REQ-028 A combinational sub-module scpad_skew_gen SHALL map (base, beat_idx, transpose, rows_m1, cols_m1) to the three masks; scpad_tile_seq owns the FSM and registers.

Verification
REQ-029 Row tile: base=10, rows_m1=3, cols_m1=31, beat_ready=1 -> 4 beats; beat 2 has all slots 12 and lane 5 shift 7; beat_last only on beat 3; req_ready=1 the cycle after.
REQ-030 Transpose tile: base=100, rows_m1=7, cols_m1=1 -> 2 beats; beat 1 has lane 3 at slot 103 and shift 4; enable=0x000000FF.
REQ-031 Wrap: base=2046, transpose, rows_m1=3 -> lane slots 2046, 2047, 0, 1.
REQ-032 Backpressure: beat_ready low for 3 cycles on beat 1 -> outputs unchanged for those cycles; no beat skipped or duplicated.
REQ-033 flush during beat 2 of a 4-beat tile, together with beat_ready=1 -> IDLE the next cycle; a new request is then accepted normally.
REQ-034 RST during RUN -> all outputs at reset values the next cycle; a single-beat tile afterwards issues exactly one beat with beat_last=1.

Source files
------------

// File: rtl/spad_types_pkg.sv
// rtl/spad_types_pkg.sv - shared sizes, mask types and tile request for the scratchpad tile sequencer
// Purpose: single home for the scratchpad geometry and the derived widths/types
//          used by the sequencer, its interface and the skew generator.
// Ports:   none (package).
package spad_types_pkg;

  // Scratchpad geometry. NUM_COLS, NUM_ROWS and MAX_TILE_SIZE must be powers
  // of 2 and MAX_TILE_SIZE <= NUM_COLS; the mask types below are sized from these.
  localparam int NUM_SCPADS    = 2;
  localparam int NUM_COLS      = 32;
  localparam int NUM_ROWS      = 2048;
  localparam int MAX_TILE_SIZE = 32;

  localparam int SCPAD_ID_WIDTH = (NUM_SCPADS > 1) ? $clog2(NUM_SCPADS) : 1;
  localparam int MAX_DIM_WIDTH  = $clog2(MAX_TILE_SIZE);
  localparam int ROW_IDX_WIDTH  = $clog2(NUM_ROWS);
  localparam int COL_IDX_WIDTH  = $clog2(NUM_COLS);

  // One entry per bank lane.
  typedef logic [NUM_COLS-1:0][ROW_IDX_WIDTH-1:0] slot_mask_t;
  typedef logic [NUM_COLS-1:0][COL_IDX_WIDTH-1:0] shift_mask_t;
  typedef logic [NUM_COLS-1:0]                    enable_mask_t;

  typedef struct packed {
    logic [SCPAD_ID_WIDTH-1:0] scpad_id;
    logic [ROW_IDX_WIDTH-1:0]  base_row;
    logic [MAX_DIM_WIDTH-1:0]  rows_m1;
    logic [MAX_DIM_WIDTH-1:0]  cols_m1;
    logic                      transpose;
  } tile_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/scpad_tile_seq_if.sv
// rtl/scpad_tile_seq_if.sv - request/beat bundle between a tile requester and the sequencer
// Purpose: groups flush, the tile-request handshake and the per-beat handshake.
// Ports:   master = requester/consumer side, slave = sequencer side.
//          flush, req_valid/req_ready, req_scpad_id, req_base_row, req_rows_m1,
//          req_cols_m1, req_transpose, beat_valid/beat_ready, beat_scpad_id,
//          beat_slot_mask, beat_shift_mask, beat_enable_mask, beat_idx,
//          beat_last, busy.
interface scpad_tile_seq_if;
  import spad_types_pkg::*;

  logic                      flush;
  logic                      req_valid;
  logic                      req_ready;
  logic [SCPAD_ID_WIDTH-1:0] req_scpad_id;
  logic [ROW_IDX_WIDTH-1:0]  req_base_row;
  logic [MAX_DIM_WIDTH-1:0]  req_rows_m1;
  logic [MAX_DIM_WIDTH-1:0]  req_cols_m1;
  logic                      req_transpose;

  logic                      beat_valid;
  logic                      beat_ready;
  logic [SCPAD_ID_WIDTH-1:0] beat_scpad_id;
  slot_mask_t                beat_slot_mask;
  shift_mask_t               beat_shift_mask;
  enable_mask_t              beat_enable_mask;
  logic [MAX_DIM_WIDTH-1:0]  beat_idx;
  logic                      beat_last;
  logic                      busy;

  modport master (
    output flush, req_valid, req_scpad_id, req_base_row, req_rows_m1,
           req_cols_m1, req_transpose, beat_ready,
    input  req_ready, beat_valid, beat_scpad_id, beat_slot_mask,
           beat_shift_mask, beat_enable_mask, beat_idx, beat_last, busy
  );

  modport slave (
    input  flush, req_valid, req_scpad_id, req_base_row, req_rows_m1,
           req_cols_m1, req_transpose, beat_ready,
    output req_ready, beat_valid, beat_scpad_id, beat_slot_mask,
           beat_shift_mask, beat_enable_mask, beat_idx, beat_last, busy
  );

endinterface

// File: rtl/scpad_skew_gen.sv
// rtl/scpad_skew_gen.sv - combinational per-lane slot/shift/enable generator for skewed tiles
// Purpose: element (r,c) lives in bank (c+r) mod NUM_COLS, slot (base+r) mod NUM_ROWS.
//          Row mode walks r = beat_idx with lane k = column; transpose mode walks
//          c = beat_idx with lane k = row.
// Ports:   base, beat_idx, transpose, rows_m1, cols_m1 in; slot_mask,
//          shift_mask, enable_mask out. Disabled lanes output zero.
module scpad_skew_gen
  import spad_types_pkg::*;
(
  input  logic [ROW_IDX_WIDTH-1:0] base,
  input  logic [MAX_DIM_WIDTH-1:0] beat_idx,
  input  logic                     transpose,
  input  logic [MAX_DIM_WIDTH-1:0] rows_m1,
  input  logic [MAX_DIM_WIDTH-1:0] cols_m1,
  output slot_mask_t               slot_mask,
  output shift_mask_t              shift_mask,
  output enable_mask_t             enable_mask
);

  // Wrap-around of slot and shift comes for free from truncating sums to the
  // index widths.
  always_comb begin
    slot_mask   = '0;
    shift_mask  = '0;
    enable_mask = '0;
    for (int k = 0; k < NUM_COLS; k++) begin
      if (!transpose) begin
        if (k <= int'(cols_m1)) begin
          slot_mask[k]   = base + ROW_IDX_WIDTH'(beat_idx);
          shift_mask[k]  = COL_IDX_WIDTH'(k) + COL_IDX_WIDTH'(beat_idx);
          enable_mask[k] = 1'b1;
        end
      end else if (k <= int'(rows_m1)) begin
        slot_mask[k]   = base + ROW_IDX_WIDTH'(k);
        shift_mask[k]  = COL_IDX_WIDTH'(beat_idx) + COL_IDX_WIDTH'(k);
        enable_mask[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scpad_tile_seq.sv
// rtl/scpad_tile_seq.sv - tile sequencer issuing one skewed bank-access beat per row or column
// Purpose: accepts a tile request, then emits rows_m1+1 (row mode) or cols_m1+1
//          (transpose mode) beats of slot/shift/enable masks; flush aborts the tile.
// Ports:   CLK, RST (sync, active-high); bus (slave modport of scpad_tile_seq_if).
module scpad_tile_seq
  import spad_types_pkg::*;
(
  input logic              CLK,
  input logic              RST,
  scpad_tile_seq_if.slave  bus
);

  seq_state_t               state_q, state_d;
  tile_req_t                tile_q;
  logic [MAX_DIM_WIDTH-1:0] idx_q;
  logic [MAX_DIM_WIDTH-1:0] last_idx;
  logic                     run;
  logic                     accept;
  logic                     fire;
  slot_mask_t               slot_m;
  shift_mask_t              shift_m;
  enable_mask_t             enable_m;

  assign last_idx = tile_q.transpose ? tile_q.cols_m1 : tile_q.rows_m1;

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    accept  = 1'b0;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        run = 1'b1;
        if (bus.beat_ready) begin
          fire = 1'b1;
          if (idx_q == last_idx) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush overrides both handshakes in the same cycle.
    if (bus.flush) begin
      state_d = ST_IDLE;
      accept  = 1'b0;
      fire    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      tile_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tile_q <= '{scpad_id:  bus.req_scpad_id,
                    base_row:  bus.req_base_row,
                    rows_m1:   bus.req_rows_m1,
                    cols_m1:   bus.req_cols_m1,
                    transpose: bus.req_transpose};
        idx_q  <= '0;
      end else if (bus.flush) begin
        idx_q <= '0;
      end else if (fire && (idx_q != last_idx)) begin
        idx_q <= idx_q + MAX_DIM_WIDTH'(1);
      end
    end
  end

  scpad_skew_gen u_skew (
    .base        (tile_q.base_row),
    .beat_idx    (idx_q),
    .transpose   (tile_q.transpose),
    .rows_m1     (tile_q.rows_m1),
    .cols_m1     (tile_q.cols_m1),
    .slot_mask   (slot_m),
    .shift_mask  (shift_m),
    .enable_mask (enable_m)
  );

  // Beat outputs are pure functions of registered state, so they stay stable
  // under backpressure, and are zeroed outside RUN.
  assign bus.req_ready        = !run;
  assign bus.beat_valid       = run;
  assign bus.busy             = run;
  assign bus.beat_idx         = run ? idx_q : '0;
  assign bus.beat_last        = run && (idx_q == last_idx);
  assign bus.beat_scpad_id    = run ? tile_q.scpad_id : '0;
  assign bus.beat_slot_mask   = run ? slot_m : '0;
  assign bus.beat_shift_mask  = run ? shift_m : '0;
  assign bus.beat_enable_mask = run ? enable_m : '0;

endmodule

// File: tb/tb_scpad_tile_seq.sv
// tb/tb_scpad_tile_seq.sv - self-checking bench for scpad_tile_seq
module tb_scpad_tile_seq;
  import spad_types_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scpad_tile_seq_if bus();

  scpad_tile_seq dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int                        idx;
    logic                      last;
    logic [SCPAD_ID_WIDTH-1:0] id;
    slot_mask_t                s;
    shift_mask_t               h;
    enable_mask_t              e;
  } beat_rec_t;

  beat_rec_t beats[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_rec_t capture();
    beat_rec_t r;
    r.idx  = int'(bus.beat_idx);
    r.last = bus.beat_last;
    r.id   = bus.beat_scpad_id;
    r.s    = bus.beat_slot_mask;
    r.h    = bus.beat_shift_mask;
    r.e    = bus.beat_enable_mask;
    return r;
  endfunction

  // Reference: element view of the skewed layout. Row mode beat b is tile row b
  // (lane = column); transpose beat b is tile column b (lane = row).
  function automatic void model_beat(input tile_req_t t, input int b,
                                     output slot_mask_t s, output shift_mask_t h,
                                     output enable_mask_t e);
    s = '0; h = '0; e = '0;
    for (int k = 0; k < NUM_COLS; k++) begin
      int r, c;
      bit on;
      if (t.transpose) begin r = k; c = b; on = (k <= int'(t.rows_m1)); end
      else             begin r = b; c = k; on = (k <= int'(t.cols_m1)); end
      if (on) begin
        s[k] = ROW_IDX_WIDTH'((int'(t.base_row) + r) % NUM_ROWS);
        h[k] = COL_IDX_WIDTH'((r + c) % NUM_COLS);
        e[k] = 1'b1;
      end
    end
  endfunction

  function automatic int beat_count(input tile_req_t t);
    return t.transpose ? int'(t.cols_m1) + 1 : int'(t.rows_m1) + 1;
  endfunction

  task automatic set_req(input tile_req_t t);
    bus.req_scpad_id  = t.scpad_id;
    bus.req_base_row  = t.base_row;
    bus.req_rows_m1   = t.rows_m1;
    bus.req_cols_m1   = t.cols_m1;
    bus.req_transpose = t.transpose;
  endtask

  // Issues one request from IDLE and records every handshaken beat.
  task automatic drive_tile(input tile_req_t t, input int stall_pct,
                            output int timed_out, output logic rr_after);
    beat_rec_t r;
    beats.delete();
    timed_out = 1;
    rr_after  = 1'b0;
    set_req(t);
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.beat_ready = ($urandom_range(99) >= stall_pct);
      if (bus.beat_valid && bus.beat_ready) begin
        r = capture();
        beats.push_back(r);
        if (r.last) begin
          step();
          rr_after  = bus.req_ready;
          timed_out = 0;
          break;
        end
      end
      step();
    end
    bus.beat_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.beat_valid !== 1'b0) begin failures++; $display("FAIL reset_beat_valid got=%0b exp=0", bus.beat_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", bus.req_ready); end
    checks++; if (bus.beat_idx !== '0 || bus.beat_last !== 1'b0) begin failures++; $display("FAIL reset_idx_last got=%0d/%0b exp=0/0", bus.beat_idx, bus.beat_last); end
    checks++; if (bus.beat_slot_mask !== '0 || bus.beat_shift_mask !== '0 || bus.beat_enable_mask !== '0) begin
      failures++; $display("FAIL reset_masks got_en=%h exp=0", bus.beat_enable_mask);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_row_tile();
    tile_req_t t;
    int to;
    logic rr;
    slot_mask_t es; shift_mask_t eh; enable_mask_t ee;
    t = '{scpad_id: 1'b1, base_row: 11'd10, rows_m1: 5'd3, cols_m1: 5'd31, transpose: 1'b0};
    drive_tile(t, 0, to, rr);
    checks++; if (to != 0 || beats.size() != 4) begin failures++; $display("FAIL row_count got=%0d exp=4 timeout=%0d", beats.size(), to); end
    if (beats.size() == 4) begin
      checks++;
      for (int k = 0; k < NUM_COLS; k++)
        if (beats[2].s[k] !== 11'd12) begin failures++; $display("FAIL row_b2_slot lane=%0d got=%0d exp=12", k, beats[2].s[k]); break; end
      checks++; if (beats[2].h[5] !== 5'd7) begin failures++; $display("FAIL row_b2_shift5 got=%0d exp=7", beats[2].h[5]); end
      checks++; if ({beats[0].last, beats[1].last, beats[2].last, beats[3].last} !== 4'b0001) begin
        failures++; $display("FAIL row_last got=%b exp=0001", {beats[0].last, beats[1].last, beats[2].last, beats[3].last});
      end
    end
    checks++; if (rr !== 1'b1) begin failures++; $display("FAIL row_ready_after got=%0b exp=1", rr); end
    foreach (beats[b]) begin
      model_beat(t, b, es, eh, ee);
      checks++;
      if (beats[b].idx != b || beats[b].s !== es || beats[b].h !== eh || beats[b].e !== ee || beats[b].id !== t.scpad_id) begin
        failures++; $display("FAIL row_model beat=%0d got_idx=%0d got_en=%h exp_en=%h", b, beats[b].idx, beats[b].e, ee);
      end
    end
  endtask

  task automatic test_transpose_tile();
    tile_req_t t;
    int to;
    logic rr;
    slot_mask_t es; shift_mask_t eh; enable_mask_t ee;
    t = '{scpad_id: 1'b0, base_row: 11'd100, rows_m1: 5'd7, cols_m1: 5'd1, transpose: 1'b1};
    drive_tile(t, 0, to, rr);
    checks++; if (to != 0 || beats.size() != 2) begin failures++; $display("FAIL tr_count got=%0d exp=2 timeout=%0d", beats.size(), to); end
    if (beats.size() == 2) begin
      checks++; if (beats[1].s[3] !== 11'd103 || beats[1].h[3] !== 5'd4) begin
        failures++; $display("FAIL tr_lane3 got slot=%0d shift=%0d exp slot=103 shift=4", beats[1].s[3], beats[1].h[3]);
      end
      checks++; if (beats[0].e !== 32'h0000_00FF || beats[1].e !== 32'h0000_00FF) begin
        failures++; $display("FAIL tr_enable got=%h/%h exp=000000ff", beats[0].e, beats[1].e);
      end
      checks++; if (beats[1].s[8] !== '0 || beats[1].h[8] !== '0) begin
        failures++; $display("FAIL tr_disabled_lane got slot=%0d shift=%0d exp=0/0", beats[1].s[8], beats[1].h[8]);
      end
    end
    foreach (beats[b]) begin
      model_beat(t, b, es, eh, ee);
      checks++;
      if (beats[b].s !== es || beats[b].h !== eh || beats[b].e !== ee || beats[b].last !== (b == beats.size() - 1)) begin
        failures++; $display("FAIL tr_model beat=%0d got_last=%0b got_en=%h exp_en=%h", b, beats[b].last, beats[b].e, ee);
      end
    end
  endtask

  task automatic test_wrap();
    tile_req_t t;
    int to;
    logic rr;
    int exp_w[4] = '{2046, 2047, 0, 1};
    t = '{scpad_id: 1'b0, base_row: 11'd2046, rows_m1: 5'd3, cols_m1: 5'd0, transpose: 1'b1};
    drive_tile(t, 0, to, rr);
    checks++; if (to != 0 || beats.size() != 1) begin failures++; $display("FAIL wrap_count got=%0d exp=1", beats.size()); end
    if (beats.size() == 1) begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (int'(beats[0].s[k]) != exp_w[k]) begin failures++; $display("FAIL wrap_slot lane=%0d got=%0d exp=%0d", k, beats[0].s[k], exp_w[k]); end
      end
    end
  endtask

  task automatic test_backpressure();
    tile_req_t t, other;
    beat_rec_t held, cur;
    int seen[$];
    int done;
    slot_mask_t es; shift_mask_t eh; enable_mask_t ee;
    t     = '{scpad_id: 1'b1, base_row: 11'd500, rows_m1: 5'd3, cols_m1: 5'd15, transpose: 1'b0};
    other = '{scpad_id: 1'b0, base_row: 11'd7, rows_m1: 5'd9, cols_m1: 5'd2, transpose: 1'b1};
    set_req(t);
    bus.req_valid = 1'b1;
    step();
    bus.req_valid  = 1'b0;
    bus.beat_ready = 1'b1;
    step();
    bus.beat_ready = 1'b0;
    held = capture();
    model_beat(t, 1, es, eh, ee);
    checks++; if (held.idx != 1 || held.s !== es || held.h !== eh || held.e !== ee) begin
      failures++; $display("FAIL bp_beat1 got_idx=%0d got_en=%h exp_en=%h", held.idx, held.e, ee);
    end
    // A request presented while running must be ignored.
    set_req(other);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      cur = capture();
      checks++;
      if (bus.beat_valid !== 1'b1 || cur.idx != held.idx || cur.last !== held.last || cur.id !== held.id ||
          cur.s !== held.s || cur.h !== held.h || cur.e !== held.e) begin
        failures++; $display("FAIL bp_hold cycle=%0d got_idx=%0d exp_idx=%0d got_en=%h exp_en=%h", c, cur.idx, held.idx, cur.e, held.e);
      end
    end
    bus.req_valid  = 1'b0;
    bus.beat_ready = 1'b1;
    done = 0;
    for (int c = 0; c < 20 && done == 0; c++) begin
      if (bus.beat_valid) begin
        seen.push_back(int'(bus.beat_idx));
        if (bus.beat_last) done = 1;
      end
      step();
    end
    bus.beat_ready = 1'b0;
    checks++; if (done == 0 || seen.size() != 3 || seen[0] != 1 || seen[1] != 2 || seen[2] != 3) begin
      failures++; $display("FAIL bp_sequence got_n=%0d exp=3 (1,2,3) done=%0d", seen.size(), done);
    end
  endtask

  task automatic test_flush();
    tile_req_t t, t2;
    int to;
    logic rr;
    slot_mask_t es; shift_mask_t eh; enable_mask_t ee;
    t  = '{scpad_id: 1'b0, base_row: 11'd33, rows_m1: 5'd3, cols_m1: 5'd7, transpose: 1'b0};
    t2 = '{scpad_id: 1'b1, base_row: 11'd2040, rows_m1: 5'd12, cols_m1: 5'd2, transpose: 1'b1};
    set_req(t);
    bus.req_valid = 1'b1;
    step();
    bus.req_valid  = 1'b0;
    bus.beat_ready = 1'b1;
    step();
    step();
    checks++; if (bus.beat_idx !== 5'd2 || bus.beat_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_idx got=%0d exp=2", bus.beat_idx); end
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    step();
    bus.flush      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.beat_ready = 1'b0;
    checks++; if (bus.req_ready !== 1'b1 || bus.beat_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL flush_idle got ready=%0b valid=%0b busy=%0b exp=1/0/0", bus.req_ready, bus.beat_valid, bus.busy);
    end
    drive_tile(t2, 20, to, rr);
    checks++; if (to != 0 || beats.size() != 3) begin failures++; $display("FAIL flush_next_count got=%0d exp=3", beats.size()); end
    foreach (beats[b]) begin
      model_beat(t2, b, es, eh, ee);
      checks++;
      if (beats[b].idx != b || beats[b].s !== es || beats[b].h !== eh || beats[b].e !== ee) begin
        failures++; $display("FAIL flush_next_model beat=%0d got_idx=%0d got_en=%h exp_en=%h", b, beats[b].idx, beats[b].e, ee);
      end
    end
  endtask

  task automatic test_reset_during_run();
    tile_req_t t, t1;
    int to;
    logic rr;
    t  = '{scpad_id: 1'b1, base_row: 11'd300, rows_m1: 5'd5, cols_m1: 5'd9, transpose: 1'b0};
    t1 = '{scpad_id: 1'b1, base_row: 11'd77, rows_m1: 5'd0, cols_m1: 5'd3, transpose: 1'b0};
    set_req(t);
    bus.req_valid = 1'b1;
    step();
    bus.req_valid  = 1'b0;
    bus.beat_ready = 1'b1;
    step();
    rst       = 1'b1;
    bus.flush = 1'b1;
    step();
    rst            = 1'b0;
    bus.flush      = 1'b0;
    bus.beat_ready = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.beat_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.beat_idx !== '0 ||
        bus.beat_last !== 1'b0 || bus.beat_slot_mask !== '0 || bus.beat_shift_mask !== '0 || bus.beat_enable_mask !== '0) begin
      failures++; $display("FAIL rst_run_outputs got busy=%0b valid=%0b ready=%0b idx=%0d en=%h exp=0/0/1/0/0", bus.busy, bus.beat_valid, bus.req_ready, bus.beat_idx, bus.beat_enable_mask);
    end
    drive_tile(t1, 0, to, rr);
    checks++; if (to != 0 || beats.size() != 1) begin failures++; $display("FAIL one_beat_count got=%0d exp=1", beats.size()); end
    if (beats.size() == 1) begin
      checks++; if (beats[0].last !== 1'b1 || beats[0].idx != 0 || beats[0].e !== 32'h0000_000F) begin
        failures++; $display("FAIL one_beat_fields got last=%0b idx=%0d en=%h exp=1/0/0000000f", beats[0].last, beats[0].idx, beats[0].e);
      end
    end
    checks++; if (rr !== 1'b1 || bus.beat_valid !== 1'b0) begin failures++; $display("FAIL one_beat_after got ready=%0b valid=%0b exp=1/0", rr, bus.beat_valid); end
  endtask

  task automatic test_random();
    tile_req_t t;
    int to, n;
    logic rr;
    slot_mask_t es; shift_mask_t eh; enable_mask_t ee;
    for (int i = 0; i < 25; i++) begin
      t.scpad_id  = SCPAD_ID_WIDTH'($urandom_range(NUM_SCPADS - 1));
      t.base_row  = ROW_IDX_WIDTH'($urandom_range(NUM_ROWS - 1));
      t.rows_m1   = MAX_DIM_WIDTH'($urandom_range(MAX_TILE_SIZE - 1));
      t.cols_m1   = MAX_DIM_WIDTH'($urandom_range(MAX_TILE_SIZE - 1));
      t.transpose = 1'($urandom_range(1));
      n = beat_count(t);
      drive_tile(t, 30, to, rr);
      checks++; if (to != 0 || beats.size() != n || rr !== 1'b1) begin
        failures++; $display("FAIL rand_count tile=%0d got=%0d exp=%0d timeout=%0d ready_after=%0b", i, beats.size(), n, to, rr);
      end
      foreach (beats[b]) begin
        model_beat(t, b, es, eh, ee);
        checks++;
        if (beats[b].idx != b || beats[b].last !== (b == n - 1) || beats[b].id !== t.scpad_id ||
            beats[b].s !== es || beats[b].h !== eh || beats[b].e !== ee) begin
          failures++;
          $display("FAIL rand_beat tile=%0d beat=%0d got_idx=%0d got_last=%0b got_en=%h exp_en=%h got_shift=%h exp_shift=%h",
                   i, b, beats[b].idx, beats[b].last, beats[b].e, ee, beats[b].h, eh);
        end
      end
      step();
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.beat_ready = 1'b0;
    set_req('0);
    test_reset();
    test_row_tile();
    test_transpose_tile();
    test_wrap();
    test_backpressure();
    test_flush();
    test_reset_during_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
